// File: rtl/mips_pkg.sv
// Shared MIPS-side constants: program buffer geometry, HALT encoding and the
// issue-unit state encoding.
package mips_pkg;

    localparam int          DEPTH     = 16;
    localparam int          AW        = 4;
    localparam int          OP_MSB    = 31;
    localparam int          OP_LSB    = 26;
    localparam logic [5:0]  OP_HALT   = 6'b111111;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_OFFER = 2'd2,
        ST_DONE  = 2'd3
    } issue_state_t;

    // Only the exact HALT word ends a program; other opcode-63 words issue normally.
    function automatic logic is_halt(input logic [31:0] word);
        return word == HALT_WORD;
    endfunction

endpackage

// File: rtl/instr_buffer.sv
// Program store: DEPTH x 32 words, synchronous write, combinational read so
// the FETCH state sees mem[pc] in the same cycle.
module instr_buffer
    import mips_pkg::*;
(
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    // Contents deliberately survive reset so a program can be replayed.
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_issue_unit.sv
// Instruction-side responder for the multicycle core: program buffer plus a
// PC sequencer that offers one word per FETCH/OFFER pair until HALT.
module instr_issue_unit
    import mips_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
    output logic [31:0]   instr_out,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic [15:0]   issued_cnt
);

    issue_state_t  state_reg;
    logic [AW-1:0] pc_reg;
    logic [31:0]   instr_out_reg;
    logic          instr_valid_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [15:0]   issued_cnt_reg;

    logic          quiescent;
    logic          mem_we;
    logic [31:0]   fetch_word;

    assign quiescent = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign mem_we    = load_en && quiescent;

    instr_buffer u_buffer (
        .clock   (clock),
        .wr_en   (mem_we),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (pc_reg),
        .rd_data (fetch_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= '0;
            instr_out_reg   <= '0;
            instr_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            issued_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        pc_reg         <= '0;
                        issued_cnt_reg <= '0;
                        done_reg       <= 1'b0;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // A redirect discards whatever was read at the old PC.
                    if (redirect) begin
                        pc_reg          <= redirect_pc;
                        instr_valid_reg <= 1'b0;
                    end else if (is_halt(fetch_word)) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_DONE;
                    end else begin
                        instr_out_reg   <= fetch_word;
                        instr_valid_reg <= 1'b1;
                        state_reg       <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (redirect || instr_ready) begin
                        instr_valid_reg <= 1'b0;
                        state_reg       <= ST_FETCH;
                        // An accept coinciding with a redirect still counts the word.
                        if (instr_ready && (issued_cnt_reg != 16'hFFFF)) begin
                            issued_cnt_reg <= issued_cnt_reg + 16'd1;
                        end
                        pc_reg <= redirect ? redirect_pc : pc_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign instr_out   = instr_out_reg;
    assign instr_valid = instr_valid_reg;
    assign pc          = pc_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign issued_cnt  = issued_cnt_reg;

endmodule
